// File: rtl/egress_port_scheduler_pkg.sv
// Shared configuration and descriptor types for the egress port scheduler.
// Defaults mirror the switch-wide port count and the frame-buffer address width.
package egress_port_scheduler_pkg;

    localparam int unsigned SW_NUM_PORTS    = 4;
    localparam int unsigned MEM_ADDR_W      = 12;
    localparam int unsigned DESC_FIFO_DEPTH = 8;

    typedef logic [$clog2(SW_NUM_PORTS)-1:0] port_idx_t;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] ptr;
        port_idx_t             src;
    } egress_desc_t;

endpackage

// File: rtl/egress_port_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after rr_ptr_i wins.
module egress_port_scheduler_rr_arbiter #(
    parameter int unsigned NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0]         req_i,
    input  logic [$clog2(NUM_PORTS)-1:0] rr_ptr_i,
    output logic [NUM_PORTS-1:0]         grant_o,
    output logic                         valid_o,
    output logic [$clog2(NUM_PORTS)-1:0] idx_o
);

    localparam int unsigned IDX_W = $clog2(NUM_PORTS);

    logic [IDX_W-1:0] w_j;

    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        idx_o   = '0;
        w_j     = '0;
        for (int unsigned off = 0; off < NUM_PORTS; off++) begin
            w_j = IDX_W'((32'(rr_ptr_i) + off) % NUM_PORTS);
            if (!valid_o && req_i[w_j]) begin
                valid_o      = 1'b1;
                idx_o        = w_j;
                grant_o[w_j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/egress_port_scheduler.sv
// Per-egress-port scheduler: captures ingress forward requests, arbitrates round-robin
// and queues granted frame pointers in a show-ahead descriptor FIFO.
module egress_port_scheduler
    import egress_port_scheduler_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = SW_NUM_PORTS,
    parameter int unsigned ADDR_W     = MEM_ADDR_W,
    parameter int unsigned FIFO_DEPTH = DESC_FIFO_DEPTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_PORTS-1:0]                req_i,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]    ptr_i,
    output logic [NUM_PORTS-1:0]                drop_o,
    output logic [NUM_PORTS-1:0]                grant_o,
    output logic                                deq_valid_o,
    output logic [ADDR_W-1:0]                   deq_ptr_o,
    output logic [$clog2(NUM_PORTS)-1:0]        deq_src_o,
    input  logic                                deq_ready_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     count_o
);

    localparam int unsigned IDX_W = $clog2(NUM_PORTS);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] ptr;
        logic [IDX_W-1:0]  src;
    } desc_t;

    logic [NUM_PORTS-1:0]             r_pending, w_pending_d;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] r_held, w_held_d;
    logic [NUM_PORTS-1:0]             r_drop, w_drop_d;
    logic [NUM_PORTS-1:0]             r_grant;
    logic [IDX_W-1:0]                 r_rr_ptr;
    desc_t                            r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]                 r_wr, r_rd, w_rd_next;
    logic [CNT_W-1:0]                 r_count, w_count_next;
    desc_t                            r_head, w_head_next, w_wr_desc;

    logic                             w_space, w_push, w_pop;
    logic [NUM_PORTS-1:0]             w_arb_gnt;
    logic                             w_arb_valid;
    logic [IDX_W-1:0]                 w_arb_idx;

    // Registered count gates grants; a same-cycle pop never frees space early.
    assign w_space = (r_count < CNT_W'(FIFO_DEPTH));

    egress_port_scheduler_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
        .req_i    (r_pending & {NUM_PORTS{w_space}}),
        .rr_ptr_i (r_rr_ptr),
        .grant_o  (w_arb_gnt),
        .valid_o  (w_arb_valid),
        .idx_o    (w_arb_idx)
    );

    assign w_push    = w_arb_valid;
    assign w_pop     = (r_count != '0) && deq_ready_i;
    assign w_wr_desc = '{ptr: r_held[w_arb_idx], src: w_arb_idx};

    always_comb begin
        w_pending_d = r_pending;
        w_held_d    = r_held;
        w_drop_d    = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (req_i[i]) begin
                if (!r_pending[i] || w_arb_gnt[i]) begin
                    w_held_d[i]    = ptr_i[i];
                    w_pending_d[i] = 1'b1;
                end else begin
                    w_drop_d[i] = 1'b1;
                end
            end else if (w_arb_gnt[i]) begin
                w_pending_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        w_rd_next    = w_pop ? r_rd + 1'b1 : r_rd;
        w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_head_next  = r_head;
        // A push landing in the slot that becomes head bypasses the storage array.
        if (w_count_next != '0) begin
            w_head_next = (w_push && (r_wr == w_rd_next)) ? w_wr_desc : r_mem[w_rd_next];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= w_wr_desc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_held    <= '0;
            r_drop    <= '0;
            r_grant   <= '0;
            r_rr_ptr  <= '0;
            r_wr      <= '0;
            r_rd      <= '0;
            r_count   <= '0;
            r_head    <= '0;
        end else begin
            r_pending <= w_pending_d;
            r_held    <= w_held_d;
            r_drop    <= w_drop_d;
            r_grant   <= w_arb_gnt;
            r_rd      <= w_rd_next;
            r_count   <= w_count_next;
            r_head    <= w_head_next;
            if (w_push) begin
                r_wr     <= r_wr + 1'b1;
                r_rr_ptr <= (w_arb_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : w_arb_idx + 1'b1;
            end
        end
    end

    assign drop_o      = r_drop;
    assign grant_o     = r_grant;
    assign deq_valid_o = (r_count != '0);
    assign deq_ptr_o   = r_head.ptr;
    assign deq_src_o   = r_head.src;
    assign count_o     = r_count;

endmodule

// File: tb/tb_egress_port_scheduler.sv
// Directed scenarios plus randomized traffic, checked every cycle against a queue-based model.
module tb_egress_port_scheduler;
    import egress_port_scheduler_pkg::*;

    localparam int NP    = SW_NUM_PORTS;
    localparam int AW    = MEM_ADDR_W;
    localparam int DEPTH = DESC_FIFO_DEPTH;

    typedef logic [NP-1:0][AW-1:0] ptrv_t;
    typedef struct {
        logic [AW-1:0] ptr;
        int            src;
    } ent_t;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NP-1:0]              req;
    ptrv_t                      ptr;
    logic                       ready;
    logic [NP-1:0]              drop, grant;
    logic                       deq_valid;
    logic [AW-1:0]              deq_ptr;
    logic [$clog2(NP)-1:0]      deq_src;
    logic [$clog2(DEPTH+1)-1:0] count;

    egress_port_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .ptr_i       (ptr),
        .drop_o      (drop),
        .grant_o     (grant),
        .deq_valid_o (deq_valid),
        .deq_ptr_o   (deq_ptr),
        .deq_src_o   (deq_src),
        .deq_ready_i (ready),
        .count_o     (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit            m_pend [NP];
    logic [AW-1:0] m_held [NP];
    int            m_rr;
    ent_t          m_q [$];
    logic [NP-1:0] e_grant, e_drop;
    logic [AW-1:0] e_ptr;
    int            e_src;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
    endtask

    function automatic ptrv_t mkp(input int base);
        ptrv_t p;
        for (int i = 0; i < NP; i++) p[i] = AW'(base + i);
        return p;
    endfunction

    task automatic step(input bit r, input logic [NP-1:0] rq, input ptrv_t p, input bit rdy);
        int   k;
        bit   pop;
        ent_t ne;
        rst   = r;
        req   = rq;
        ptr   = p;
        ready = rdy;
        if (r) begin
            for (int i = 0; i < NP; i++) begin
                m_pend[i] = 0;
                m_held[i] = '0;
            end
            m_rr = 0;
            m_q.delete();
            e_grant = '0;
            e_drop  = '0;
            e_ptr   = '0;
            e_src   = 0;
        end else begin
            k = -1;
            if (m_q.size() < DEPTH) begin
                for (int o = 0; o < NP; o++) begin
                    if (k < 0 && m_pend[(m_rr + o) % NP]) k = (m_rr + o) % NP;
                end
            end
            pop = (m_q.size() > 0) && rdy;
            if (k >= 0) begin
                ne.ptr = m_held[k];
                ne.src = k;
            end
            e_drop = '0;
            for (int i = 0; i < NP; i++) begin
                if (rq[i]) begin
                    if (!m_pend[i] || k == i) begin
                        m_held[i] = p[i];
                        m_pend[i] = 1;
                    end else begin
                        e_drop[i] = 1'b1;
                    end
                end else if (k == i) begin
                    m_pend[i] = 0;
                end
            end
            if (pop) void'(m_q.pop_front());
            e_grant = '0;
            if (k >= 0) begin
                m_q.push_back(ne);
                m_rr       = (k + 1) % NP;
                e_grant[k] = 1'b1;
            end
            if (m_q.size() > 0) begin
                e_ptr = m_q[0].ptr;
                e_src = m_q[0].src;
            end
        end
        @(posedge clk);
        #1;
        check_eq("grant", 32'(grant), 32'(e_grant));
        check_eq("drop", 32'(drop), 32'(e_drop));
        check_eq("deq_valid", 32'(deq_valid), 32'(m_q.size() != 0));
        check_eq("count", 32'(count), 32'(m_q.size()));
        check_eq("deq_ptr", 32'(deq_ptr), 32'(e_ptr));
        check_eq("deq_src", 32'(deq_src), 32'(e_src));
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, '0, '0, rdy);
    endtask

    initial begin
        ptrv_t p;
        rst   = 1'b1;
        req   = '0;
        ptr   = '0;
        ready = 1'b0;
        step(1, '0, '0, 0);
        step(1, 4'b1111, mkp('h55), 1);

        // Single request from port 2
        p = '0;
        p[2] = 12'h100;
        step(0, 4'b0100, p, 0);
        idle(2, 0);
        idle(2, 1);

        // Flood contention, then drain
        step(0, 4'b1111, mkp('h200), 0);
        idle(5, 0);
        idle(5, 1);

        // Fairness between ports 0 and 2
        for (int i = 0; i < 6; i++) step(0, 4'b0101, mkp('h300 + 4 * i), 1);
        idle(4, 1);

        // Fill to full, then backpressure on port 1
        for (int i = 0; i < DEPTH; i++) step(0, 4'(1 << (i % NP)), mkp('h400 + 8 * i), 0);
        idle(3, 0);
        p = '0;
        p[1] = 12'h3AA;
        step(0, 4'b0010, p, 0);
        idle(2, 0);
        p[1] = 12'h3BB;
        step(0, 4'b0010, p, 0);
        idle(1, 1);
        idle(3, 0);
        idle(DEPTH + 3, 1);

        // Occupancy 3 with simultaneous push/pop across the wrap point
        for (int i = 0; i < 3; i++) step(0, 4'b0001, mkp('h500 + i), 0);
        idle(1, 0);
        for (int i = 0; i < 2 * DEPTH; i++) step(0, 4'(1 << (i % NP)), mkp('h600 + 4 * i), 1);
        idle(6, 1);

        // Reset mid-operation
        for (int i = 0; i < 5; i++) step(0, 4'(1 << (i % NP)), mkp('h700 + 4 * i), 0);
        idle(2, 0);
        step(0, 4'b1010, mkp('h780), 0);
        step(1, 4'b1111, mkp('h790), 1);
        step(0, 4'b1111, mkp('h7A0), 0);
        idle(3, 0);
        idle(6, 1);

        // Randomized traffic in phases of varying request density and drain rate
        for (int ph = 0; ph < 6; ph++) begin
            for (int c = 0; c < 80; c++) begin
                logic [NP-1:0] rq;
                bit            rdy;
                for (int i = 0; i < NP; i++) p[i] = AW'($urandom);
                rq  = (ph % 2 == 0) ? NP'($urandom & $urandom) : NP'($urandom);
                rdy = (ph < 2) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                step($urandom_range(0, 99) == 0, rq, p, rdy);
            end
        end
        idle(DEPTH + 4, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
